uc_multiciclo: RTL and testbench

- Multicycle control unit that sits directly upstream of the microc datapath and drives its control inputs s_inc, s_inm, we3, wez and Op.
- Consumes the datapath's Opcode and z outputs.
- Sequences every instruction through DECODE then EXEC and drives a PC enable so the datapath advances only in EXEC.
- Adds start/halt control, single-step mode and a retired-instruction counter for debug.

---
 rtl/uc_multiciclo.sv | 121 ++++++++++++
 tb/tb_uc_multiciclo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the microc datapath: sequences each instruction through
// DECODE and EXEC, with start/halt, single-step and a saturating retired-instruction counter.
module uc_multiciclo #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic [5:0]    Opcode,
    input  logic          z,
    output logic          s_inc,
    output logic          s_inm,
    output logic          we3,
    output logic          wez,
    output logic [2:0]    Op,
    output logic          pc_en,
    output logic          busy,
    output logic          halted,
    output logic [CW-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StWaitStep,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      ir_op_q, ir_op_d;
    logic            z_q, z_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_halt;

    assign is_halt     = (ir_op_q[3:0] == 4'hF);
    assign instr_count = cnt_q;

    always_comb begin
        state_d = state_q;
        ir_op_d = ir_op_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StDecode;
            end
            StDecode: begin
                ir_op_d = Opcode;
                z_d     = z;
                state_d = StExec;
            end
            StExec: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = step_mode ? StWaitStep : StDecode;
                end
            end
            StWaitStep: begin
                if (step) state_d = StDecode;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control outputs are only non-default in EXEC, so an async reset clears them at once.
    always_comb begin
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        Op     = 3'b000;
        pc_en  = 1'b0;
        busy   = (state_q == StDecode) || (state_q == StExec) || (state_q == StWaitStep);
        halted = (state_q == StHalt);
        if (state_q == StExec) begin
            pc_en = 1'b1;
            if (!ir_op_q[3]) begin
                Op  = ir_op_q[2:0];
                we3 = 1'b1;
                wez = 1'b1;
            end else begin
                case (ir_op_q[2:0])
                    3'b000: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    3'b001:  s_inc = 1'b0;
                    3'b010:  s_inc = ~z_q;
                    3'b011:  s_inc = z_q;
                    3'b111:  pc_en = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ir_op_q <= 6'b000000;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomized scoreboard bench for uc_multiciclo: the driver issues instructions and queues
// their expected EXEC controls; a negedge monitor pops and compares whenever pc_en is high.
module tb_uc_multiciclo;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step, z;
    logic [5:0]  Opcode;
    logic        s_inc, s_inm, we3, wez, pc_en, busy, halted;
    logic [2:0]  Op;
    logic [15:0] cnt16;
    logic        d2_s_inc, d2_s_inm, d2_we3, d2_wez, d2_pc_en, d2_busy, d2_halted;
    logic [2:0]  d2_Op;
    logic [1:0]  cnt2;

    uc_multiciclo #(.CW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .Opcode(Opcode), .z(z), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
        .Op(Op), .pc_en(pc_en), .busy(busy), .halted(halted), .instr_count(cnt16)
    );

    // Narrow-counter instance shares all inputs and exercises saturation.
    uc_multiciclo #(.CW(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .Opcode(Opcode), .z(z), .s_inc(d2_s_inc), .s_inm(d2_s_inm), .we3(d2_we3),
        .wez(d2_wez), .Op(d2_Op), .pc_en(d2_pc_en), .busy(d2_busy), .halted(d2_halted),
        .instr_count(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    typedef struct {
        ctrl_t       c;
        int unsigned cnt;
    } exp_t;

    exp_t        q[$];
    int unsigned retired;
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    // Instruction-set table: what the datapath should be told to do for one instruction.
    function automatic ctrl_t model(input logic [5:0] opc, input logic zf);
        ctrl_t c;
        int    kind;
        c    = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};
        kind = int'(opc[3:0]);
        if (kind < 8) begin
            c.op  = opc[2:0];
            c.we3 = 1'b1;
            c.wez = 1'b1;
        end else if (kind == 8) begin
            c.s_inm = 1'b1;
            c.we3   = 1'b1;
        end else if (kind == 9) begin
            c.s_inc = 1'b0;
        end else if (kind == 10) begin
            c.s_inc = (zf == 1'b0);
        end else if (kind == 11) begin
            c.s_inc = (zf == 1'b1);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && pc_en) begin
            if (q.size() == 0) begin
                check("unexpected_exec", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ctrl", {25'b0, s_inc, s_inm, we3, wez, Op}, {25'b0, e.c});
                check("count16", {16'b0, cnt16}, e.cnt);
                check("count2", {30'b0, cnt2}, sat3(e.cnt));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;
        #2;
        reset = 1'b0;
        q.delete();
        retired = 0;
        check("rst_ctrl", {25'b0, s_inc, s_inm, we3, wez, Op}, 32'h40);
        check("rst_status", {29'b0, pc_en, busy, halted}, 32'd0);
        check("rst_count", {16'b0, cnt16}, 32'd0);
    endtask

    task automatic run_program(input int n, input bit alu_only, input bit use_step);
        logic [5:0] opc;
        logic       zf;
        logic       sm;
        int         waitc;
        start = 1'b1;
        tick();
        for (int i = 0; i <= n; i++) begin
            if (i == n) begin
                opc = 6'($urandom) | 6'h0F;
            end else begin
                opc = 6'($urandom);
                if (alu_only) opc[3] = 1'b0;
                else if (opc[3:0] == 4'hF) opc[3:0] = 4'hC;
            end
            zf     = 1'($urandom);
            Opcode = opc;
            z      = zf;
            if (use_step) step = 1'($urandom);  // must be ignored in DECODE
            check("decode_busy", {31'b0, busy}, 32'd1);
            check("decode_pc_en", {31'b0, pc_en}, 32'd0);
            if (i < n) begin
                exp_t e;
                e.c   = model(opc, zf);
                e.cnt = retired;
                q.push_back(e);
                retired++;
            end
            tick();
            step      = 1'b0;
            sm        = use_step ? 1'($urandom) : 1'b0;
            step_mode = sm;
            Opcode    = 6'($urandom);
            z         = 1'($urandom);
            start     = 1'($urandom);
            if (i == n) begin
                check("halt_exec_pc_en", {31'b0, pc_en}, 32'd0);
                check("halt_exec_we3", {30'b0, we3, wez}, 32'd0);
            end
            tick();
            check("exec_retired", q.size(), 32'd0);
            if (i == n) break;
            if (sm) begin
                waitc = $urandom_range(0, 3);
                repeat (waitc) begin
                    check("wait_pc_en", {31'b0, pc_en}, 32'd0);
                    check("wait_busy", {31'b0, busy}, 32'd1);
                    tick();
                end
                step = 1'b1;
                tick();
                step = 1'b0;
            end
        end
        for (int k = 0; k < 10; k++) begin
            check("halted", {30'b0, halted, busy}, 32'd2);
            check("halt_count16", {16'b0, cnt16}, retired);
            check("halt_count2", {30'b0, cnt2}, sat3(retired));
            start = ~start;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        Opcode = 6'b0; z = 1'b0; retired = 0;
        #2;
        do_reset();
        tick();
        tick();
        check("idle_hold", {30'b0, busy, pc_en}, 32'd0);

        run_program(3, 1'b1, 1'b0);
        tick();
        do_reset();
        run_program(40, 1'b0, 1'b1);
        tick();
        do_reset();
        run_program(30, 1'b0, 1'b0);
        tick();
        do_reset();
        run_program(6, 1'b0, 1'b1);

        // Reset between edges during an ALU EXEC must kill the writes immediately.
        tick();
        do_reset();
        start  = 1'b1;
        tick();
        Opcode = 6'b000010;
        z      = 1'b0;
        begin
            exp_t e;
            e.c   = model(6'b000010, 1'b0);
            e.cnt = 0;
            q.push_back(e);
            retired = 1;
        end
        tick();
        tick();
        check("first_count", {16'b0, cnt16}, 32'd1);
        Opcode = 6'b000010;
        tick();
        check("pre_rst_writes", {29'b0, we3, wez, pc_en}, 32'd7);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_writes", {29'b0, we3, wez, pc_en}, 32'd0);
        check("mid_rst_state", {30'b0, busy, halted}, 32'd0);
        check("mid_rst_count", {16'b0, cnt16}, 32'd0);
        start = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_idle", {30'b0, busy, pc_en}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
